// File: rtl/pmp_csr_bank_if.sv
// pmp_csr_bank_if: CSR-unit side of the PMP CSR bank.
//   master (CSR unit): drives StallW, CSRMWriteM, CSRAdrM and CSRWriteValM,
//                      receives CSRPMPReadValM and IllegalPMPAccessM.
//   slave  (bank)    : the mirror image of master.
interface pmp_csr_bank_if #(
    parameter int XLEN = 64
);
    logic            StallW;
    logic            CSRMWriteM;
    logic [11:0]     CSRAdrM;
    logic [XLEN-1:0] CSRWriteValM;
    logic [XLEN-1:0] CSRPMPReadValM;
    logic            IllegalPMPAccessM;

    modport master (
        output StallW, CSRMWriteM, CSRAdrM, CSRWriteValM,
        input  CSRPMPReadValM, IllegalPMPAccessM
    );

    modport slave (
        input  StallW, CSRMWriteM, CSRAdrM, CSRWriteValM,
        output CSRPMPReadValM, IllegalPMPAccessM
    );
endinterface

// File: rtl/pmp_csr_bank.sv
// pmp_csr_bank: machine-mode pmpcfg/pmpaddr register file.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : CSR write strobe/address/data, stall, read data,
//                         illegal-address flag
//   PMPCFG_ARRAY_REGW   : per-entry cfg byte {L,0,0,A[1:0],X,W,R}
//   PMPADDR_ARRAY_REGW  : per-entry address PA[PA_BITS-1:2]
// With PMP_ENTRIES=0 a single dummy slot keeps the output arrays legal;
// it is tied to zero and holds no state.

// One PMP entry: a cfg byte and an address register with WARL and lock rules.
module pmp_csr_entry #(
    parameter int AW = 54
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfgWe,
    input  logic [7:0]    cfgWdata,
    input  logic          addrWe,
    input  logic [AW-1:0] addrWdata,
    input  logic          nextTorLock,  // entry i+1 is locked TOR
    output logic [7:0]    cfg,
    output logic [AW-1:0] addr
);
    logic [7:0] cfgWarl;

    // Bits 6:5 dropped; W only kept alongside R.
    assign cfgWarl = {cfgWdata[7], 2'b00, cfgWdata[4:3], cfgWdata[2],
                      cfgWdata[1] & cfgWdata[0], cfgWdata[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg  <= '0;
            addr <= '0;
        end else begin
            // Lock checks use the pre-write cfg, so setting L takes effect
            // and blocks only later writes.
            if (cfgWe && !cfg[7])
                cfg <= cfgWarl;
            if (addrWe && !cfg[7] && !nextTorLock)
                addr <= addrWdata;
        end
    end
endmodule

module pmp_csr_bank #(
    parameter int XLEN        = 64,
    parameter int PMP_ENTRIES = 16,
    parameter int PA_BITS     = 56,
    localparam int NE         = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1,
    localparam int AW         = PA_BITS - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    pmp_csr_bank_if.slave           bus,
    output logic [NE-1:0][7:0]      PMPCFG_ARRAY_REGW,
    output logic [NE-1:0][AW-1:0]   PMPADDR_ARRAY_REGW
);
    localparam int BYTES    = XLEN / 8;   // cfg bytes per pmpcfg CSR
    localparam int CFG_STEP = BYTES / 4;  // RV64 uses even pmpcfg numbers only

    logic [11:0]   adr;
    logic [5:0]    addrIdx;
    logic          cfgHit, addrHit, illegal, wrEn;
    logic [AW-1:0] addrWdata;

    assign adr     = bus.CSRAdrM;
    assign cfgHit  = (adr[11:4] == 8'h3A);
    assign addrHit = (adr >= 12'h3B0) && (adr <= 12'h3EF);
    // Low six bits of 0x3B0 are 0x30; the wrap gives K = 0..63 on a hit.
    assign addrIdx = adr[5:0] - 6'h30;
    assign illegal = (XLEN == 64) && cfgHit && adr[0];
    assign wrEn    = bus.CSRMWriteM && !bus.StallW;

    assign bus.IllegalPMPAccessM = illegal;

    // pmpaddr write data: low AW bits, zero-filled above XLEN on RV32.
    generate
        if (XLEN >= AW) begin : gWdTrunc
            assign addrWdata = bus.CSRWriteValM[AW-1:0];
        end else begin : gWdExt
            assign addrWdata = {{(AW-XLEN){1'b0}}, bus.CSRWriteValM};
        end
    endgenerate

    generate
        if (PMP_ENTRIES > 0) begin : gEntries
            logic [NE-1:0]           torLock;
            logic [NE-1:0][XLEN-1:0] rdPart;
            logic [XLEN-1:0]         rdVal;

            for (genvar i = 0; i < NE; i++) begin : gEnt
                localparam int CSR_N    = (i / BYTES) * CFG_STEP;
                localparam int BYTE_POS = i % BYTES;

                logic            cfgSel, addrSel, nextTor;
                logic [XLEN-1:0] addrRd;

                assign cfgSel  = cfgHit && !illegal && (adr[3:0] == 4'(CSR_N));
                assign addrSel = addrHit && (addrIdx == 6'(i));

                if (i + 1 < NE) begin : gNext
                    assign nextTor = torLock[i+1];
                end else begin : gLast
                    assign nextTor = 1'b0;
                end

                pmp_csr_entry #(.AW(AW)) uEntry (
                    .clk         (clk),
                    .reset       (reset),
                    .cfgWe       (wrEn && cfgSel),
                    .cfgWdata    (bus.CSRWriteValM[8*BYTE_POS +: 8]),
                    .addrWe      (wrEn && addrSel),
                    .addrWdata   (addrWdata),
                    .nextTorLock (nextTor),
                    .cfg         (PMPCFG_ARRAY_REGW[i]),
                    .addr        (PMPADDR_ARRAY_REGW[i])
                );

                assign torLock[i] = PMPCFG_ARRAY_REGW[i][7] &&
                                    (PMPCFG_ARRAY_REGW[i][4:3] == 2'b01);

                if (XLEN >= AW) begin : gRdExt
                    assign addrRd = {{(XLEN-AW){1'b0}}, PMPADDR_ARRAY_REGW[i]};
                end else begin : gRdTrunc
                    assign addrRd = PMPADDR_ARRAY_REGW[i][XLEN-1:0];
                end

                // At most one entry contributes for any address.
                assign rdPart[i] = cfgSel  ? ({{(XLEN-8){1'b0}}, PMPCFG_ARRAY_REGW[i]} << (8*BYTE_POS)) :
                                   addrSel ? addrRd : '0;
            end

            always_comb begin
                rdVal = '0;
                for (int i = 0; i < NE; i++)
                    rdVal = rdVal | rdPart[i];
            end

            assign bus.CSRPMPReadValM = rdVal;
        end else begin : gNone
            assign PMPCFG_ARRAY_REGW  = '0;
            assign PMPADDR_ARRAY_REGW = '0;
            assign bus.CSRPMPReadValM = '0;
        end
    endgenerate
endmodule

// File: tb/tb_pmp_csr_bank.sv
module tb_pmp_csr_bank;
    localparam int XLEN = 64;
    localparam int NENT = 16;
    localparam int PAB  = 56;
    localparam int AW   = PAB - 2;
    localparam int NVEC = 41;

    typedef struct {
        logic        wr;
        logic        stall;
        logic [11:0] adr;
        logic [63:0] wdata;
        logic [63:0] expRd;   // read value seen during the cycle (pre-write)
        logic        expIll;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [NENT-1:0][7:0]    cfgArr;
    logic [NENT-1:0][AW-1:0] addrArr;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[NVEC];

    pmp_csr_bank_if #(.XLEN(XLEN)) bus ();

    pmp_csr_bank #(.XLEN(XLEN), .PMP_ENTRIES(NENT), .PA_BITS(PAB)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .PMPCFG_ARRAY_REGW  (cfgArr),
        .PMPADDR_ARRAY_REGW (addrArr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Drive a cycle's inputs after the falling edge; outputs are stable 1ns later.
    task automatic drive(input logic wr, input logic stall, input logic [11:0] adr,
                         input logic [63:0] wdata);
        @(negedge clk);
        bus.CSRMWriteM   = wr;
        bus.StallW       = stall;
        bus.CSRAdrM      = adr;
        bus.CSRWriteValM = wdata;
        #1;
    endtask

    initial begin
        // wr, stall, adr, wdata, expRd, expIll
        vecs[0]  = '{1'b0, 1'b0, 12'h3A0, 64'h0, 64'h1F0B, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 12'h3A1, 64'h0, 64'h0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 12'h3A2, 64'h00FF6203, 64'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 12'h3A2, 64'h0, 64'h9F0003, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 12'h3A2, 64'h0, 64'h9F0003, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 12'h3A2, 64'h0, 64'h9F0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 12'h3A3, 64'hFF, 64'h0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 12'h3A2, 64'h0, 64'h9F0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 12'h3A0, 64'h80, 64'h1F0B, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'h3A0, 64'h0707, 64'h80, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 12'h3B0, 64'h1234, 64'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 12'h3A0, 64'h0, 64'h0780, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 12'h3B0, 64'h0, 64'h0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 12'h3A0, 64'h8880, 64'h0780, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 12'h3B0, 64'hABC, 64'h0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 12'h3B1, 64'hDEF, 64'h0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 12'h3B2, 64'h55, 64'h0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 12'h3B0, 64'h0, 64'h0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 12'h3B1, 64'h0, 64'h0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 12'h3B2, 64'h0, 64'h55, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 12'h3A0, 64'h0000_8800_0000_0000, 64'h8880, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 12'h3B4, 64'h77, 64'h0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 12'h3B5, 64'h66, 64'h0, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 12'h3B6, 64'h44, 64'h0, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 12'h3A0, 64'h0, 64'h0000_8800_0000_8880, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 12'h3B4, 64'h0, 64'h0, 1'b0};
        vecs[26] = '{1'b0, 1'b0, 12'h3B5, 64'h0, 64'h0, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 12'h3B6, 64'h0, 64'h44, 1'b0};
        vecs[28] = '{1'b1, 1'b0, 12'h3B7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        vecs[29] = '{1'b0, 1'b0, 12'h3B7, 64'h0, 64'h003F_FFFF_FFFF_FFFF, 1'b0};
        vecs[30] = '{1'b1, 1'b0, 12'h3C4, 64'h1234, 64'h0, 1'b0};
        vecs[31] = '{1'b0, 1'b0, 12'h3C4, 64'h0, 64'h0, 1'b0};
        vecs[32] = '{1'b1, 1'b0, 12'h3F0, 64'h5, 64'h0, 1'b0};
        vecs[33] = '{1'b0, 1'b0, 12'h3F0, 64'h0, 64'h0, 1'b0};
        vecs[34] = '{1'b1, 1'b1, 12'h3B3, 64'h99, 64'h0, 1'b0};
        vecs[35] = '{1'b0, 1'b0, 12'h3B3, 64'h0, 64'h0, 1'b0};
        vecs[36] = '{1'b0, 1'b0, 12'h3B3, 64'h99, 64'h0, 1'b0};
        vecs[37] = '{1'b1, 1'b0, 12'h3B3, 64'h99, 64'h0, 1'b0};
        vecs[38] = '{1'b0, 1'b0, 12'h3B3, 64'h0, 64'h99, 1'b0};
        vecs[39] = '{1'b1, 1'b0, 12'h3A8, 64'h80, 64'h0, 1'b0};
        vecs[40] = '{1'b0, 1'b0, 12'h3A8, 64'h0, 64'h0, 1'b0};

        reset            = 1'b1;
        bus.CSRMWriteM   = 1'b0;
        bus.StallW       = 1'b0;
        bus.CSRAdrM      = 12'h000;
        bus.CSRWriteValM = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state: arrays and every address in the range read zero.
        #1;
        for (int i = 0; i < NENT; i++) begin
            chk($sformatf("rst_cfg%0d", i), 64'(cfgArr[i]), 64'h0);
            chk($sformatf("rst_addr%0d", i), 64'(addrArr[i]), 64'h0);
        end
        for (int a = 12'h3A0; a <= 12'h3EF; a++) begin
            drive(1'b0, 1'b0, 12'(a), 64'h0);
            chk($sformatf("rst_rd_%h", a), bus.CSRPMPReadValM, 64'h0);
            chk($sformatf("rst_ill_%h", a), 64'(bus.IllegalPMPAccessM),
                (a < 12'h3B0 && (a % 2) == 1) ? 64'h1 : 64'h0);
        end

        // First cfg write lands on the next edge.
        drive(1'b1, 1'b0, 12'h3A0, 64'h0000_0000_0000_1F0B);
        chk("cfgw_old_rd", bus.CSRPMPReadValM, 64'h0);
        chk("cfgw_cfg1_pre", 64'(cfgArr[1]), 64'h0);
        drive(1'b0, 1'b0, 12'h3A0, 64'h0);
        chk("cfgw_cfg0", 64'(cfgArr[0]), 64'h0B);
        chk("cfgw_cfg1", 64'(cfgArr[1]), 64'h1F);

        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].wr, vecs[v].stall, vecs[v].adr, vecs[v].wdata);
            chk($sformatf("vec%0d_rd", v), bus.CSRPMPReadValM, vecs[v].expRd);
            chk($sformatf("vec%0d_ill", v), 64'(bus.IllegalPMPAccessM), 64'(vecs[v].expIll));
        end

        drive(1'b0, 1'b0, 12'h000, 64'h0);
        chk("fin_cfg0", 64'(cfgArr[0]), 64'h80);
        chk("fin_cfg1", 64'(cfgArr[1]), 64'h88);
        chk("fin_cfg5", 64'(cfgArr[5]), 64'h88);
        chk("fin_cfg8", 64'(cfgArr[8]), 64'h00);
        chk("fin_cfg9", 64'(cfgArr[9]), 64'h00);
        chk("fin_cfg10", 64'(cfgArr[10]), 64'h9F);
        chk("fin_addr0", 64'(addrArr[0]), 64'h0);
        chk("fin_addr2", 64'(addrArr[2]), 64'h55);
        chk("fin_addr3", 64'(addrArr[3]), 64'h99);
        chk("fin_addr4", 64'(addrArr[4]), 64'h0);
        chk("fin_addr6", 64'(addrArr[6]), 64'h44);
        chk("fin_addr7", 64'(addrArr[7]), 64'h003F_FFFF_FFFF_FFFF);

        // Reset alongside a write: reset wins, locks clear.
        @(negedge clk);
        reset            = 1'b1;
        bus.CSRMWriteM   = 1'b1;
        bus.CSRAdrM      = 12'h3B0;
        bus.CSRWriteValM = 64'h42;
        @(negedge clk);
        reset          = 1'b0;
        bus.CSRMWriteM = 1'b0;
        #1;
        for (int i = 0; i < NENT; i++) begin
            chk($sformatf("rst2_cfg%0d", i), 64'(cfgArr[i]), 64'h0);
            chk($sformatf("rst2_addr%0d", i), 64'(addrArr[i]), 64'h0);
        end
        chk("rst2_rd", bus.CSRPMPReadValM, 64'h0);
        drive(1'b1, 1'b0, 12'h3B0, 64'h42);
        chk("rst2_wr_old", bus.CSRPMPReadValM, 64'h0);
        drive(1'b0, 1'b0, 12'h3B0, 64'h0);
        chk("rst2_wr_new", bus.CSRPMPReadValM, 64'h42);
        chk("rst2_addr0", 64'(addrArr[0]), 64'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pmp_csr_bank.md
Name: pmp_csr_bank

Overview:
- Machine-mode CSR storage for physical memory protection: the pmpcfg and pmpaddr register file.
- Decodes CSR writes from the M-stage CSR unit and applies the WARL and lock rules.
- Drives the per-entry configuration and address arrays consumed directly by the PMP checker.
- Supplies CSR read data for the pmpcfg/pmpaddr address range.

Parameters:
- XLEN, 64, CSR width; 32 or 64 only.
- PMP_ENTRIES, 16, implemented PMP entries; 0, 16 or 64.
- PA_BITS, 56, physical address width; stored pmpaddr width is PA_BITS-2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- StallW  input  1  pipeline stall; suppresses all CSR writes while high.
- CSRMWriteM  input  1  machine CSR write strobe.
- CSRAdrM  input  12  CSR address.
- CSRWriteValM  input  XLEN  CSR write data.
- PMPCFG_ARRAY_REGW  output  8 x PMP_ENTRIES  per-entry cfg byte {L,0,0,A[1:0],X,W,R}.
- PMPADDR_ARRAY_REGW  output  (PA_BITS-2) x PMP_ENTRIES  per-entry address, i.e. PA[PA_BITS-1:2].
- CSRPMPReadValM  output  XLEN  read data for CSRAdrM; combinational.
- IllegalPMPAccessM  output  1  CSRAdrM is an odd pmpcfg address (0x3A1..0x3AF) while XLEN=64.

Behaviour:
- Address map:
  - pmpcfgN is at 0x3A0+N.
  - RV32: pmpcfgN holds entries 4N..4N+3, in byte order LSB first.
  - RV64: only even N exist; pmpcfgN holds entries 4N..4N+7.
  - pmpaddrK is at 0x3B0+K, for K = 0..63.
- Write enable: WE = CSRMWriteM & ~StallW & (address decode hit).
  - A write updates the registers at the next rising clk edge; there is no other latency.
  - Odd pmpcfg addresses when XLEN=64 assert IllegalPMPAccessM (combinational) and never write.
- Read path:
  - CSRPMPReadValM reflects current register contents.
  - A read and a write to the same CSR in the same cycle returns the old value.
  - pmpaddr reads are zero-extended to XLEN.
  - Entries with index >= PMP_ENTRIES read 0 and ignore writes; this is not illegal.
  - Addresses outside 0x3A0..0x3EF read 0.
- cfg byte WARL, applied per byte and independently of the other bytes in the same CSR:
  - Bits 6:5 are always stored as 0.
  - W is stored as W & R, so the reserved combination R=0,W=1 is never stored.
  - A and X are stored as written.
- Lock rules (evaluated against pre-write register values):
  - cfg byte i with L=1 ignores writes; the rest of that CSR still updates.
  - pmpaddr i ignores writes if cfg[i].L=1.
  - pmpaddr i also ignores writes if i+1 < PMP_ENTRIES and cfg[i+1].L=1 and cfg[i+1].A=TOR (01).
  - A write that sets L in byte i takes effect normally; only subsequent writes are blocked.
  - L is sticky: once set, only reset clears it.
- pmpaddr write stores CSRWriteValM[PA_BITS-3:0]. When XLEN=32, upper bits beyond XLEN are stored as 0.
- Reset:
  - All cfg bytes = 0x00 (A=OFF, unlocked); all pmpaddr = 0; CSRPMPReadValM then reads 0.
  - Reset asserted in the same cycle as a write: reset wins, and no write is applied.
- PMP_ENTRIES=0: outputs are empty arrays; all reads return 0; all writes are ignored.
- State elements: PMP_ENTRIES cfg bytes plus PMP_ENTRIES address registers. No other state.

Test Plan:
1. Reset, then read every pmpcfg/pmpaddr address -> all 0; IllegalPMPAccessM=0 for 0x3A0, and =1 for 0x3A1 when XLEN=64.
2. XLEN=64: write 0x3A0 = 0x0000_0000_0000_1F0B -> cfg0=0x0B, cfg1=0x1F; on the next cycle PMPCFG_ARRAY_REGW[1]=0x1F and a read of 0x3A0 returns 0x1F0B. A byte 0x62 stores as 0x00 (bits 6:5 dropped, W cleared since R=0).
3. Write cfg0=0x80 (L set, OFF), then write 0x3A0=0x0707 and pmpaddr0=0x1234 -> cfg0 stays 0x80, cfg1=0x07, pmpaddr0 unchanged.
4. TOR lock: cfg1=0x88 (L, TOR); write pmpaddr0=0xABC -> ignored; write pmpaddr1=0xDEF -> ignored; write pmpaddr2=0x55 -> accepted.
5. StallW=1 with CSRMWriteM=1 to pmpaddr3 -> no change. Same write with StallW=0 -> pmpaddr3 updates at the next edge, and a same-cycle read of pmpaddr3 returns the old value.
6. Set several L bits, then assert reset for 1 cycle alongside a write -> all registers 0, locks cleared; a following write to pmpaddr0 is accepted.
